// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner and 2-entry fetch queue between instruction memory and decode
// Optional IF_WRAP_EN: PC wraps to 0 at end of memory instead of entering HALT.
module instruction_fetch #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted
);

    typedef enum logic {RUN, HALT} state_t;

    state_t        state, state_next;
    logic [AW-1:0] pc, pc_next;
    logic [1:0]    count;
    logic [31:0]   q_instr [2];
    logic [AW-1:0] q_pc    [2];
    logic          pop, fetch, wr_idx;
    logic          branch_unused;

    assign branch_unused = ^branch_target[31:AW];

    always_comb begin
        state_next = state;
        pc_next    = pc;
        pop        = (count != 2'd0) & out_ready;
        fetch      = (state == RUN) & ~branch_valid & ((count < 2'd2) | pop);
        // After a pop from a one-deep queue the new word lands in the head slot
        wr_idx     = pop ? 1'b0 : count[0];
        if (branch_valid) begin
            state_next = RUN;
            pc_next    = branch_target[AW-1:0];
        end else if (fetch) begin
            if (pc == AW'(DEPTH - 1)) begin
`ifdef IF_WRAP_EN
                pc_next = '0;
`else
                state_next = HALT;
`endif
            end else begin
                pc_next = pc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            pc         <= '0;
            count      <= 2'd0;
            q_instr[0] <= '0;
            q_instr[1] <= '0;
            q_pc[0]    <= '0;
            q_pc[1]    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (branch_valid) begin
                count <= 2'd0;
            end else begin
                if (pop && count == 2'd2) begin
                    q_instr[0] <= q_instr[1];
                    q_pc[0]    <= q_pc[1];
                    if (fetch) begin
                        q_instr[1] <= imem_data;
                        q_pc[1]    <= pc;
                    end
                end else if (fetch) begin
                    q_instr[wr_idx] <= imem_data;
                    q_pc[wr_idx]    <= pc;
                end
                count <= count + {1'b0, fetch} - {1'b0, pop};
            end
        end
    end

    assign imem_addr = {{(32-AW){1'b0}}, pc};
    assign out_valid = (count != 2'd0);
    assign out_instr = q_instr[0];
    assign out_pc    = {{(32-AW){1'b0}}, q_pc[0]};
`ifdef IF_WRAP_EN
    assign halted    = 1'b0;
`else
    assign halted    = (state == HALT);
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized bench for instruction_fetch against a queue-based reference model
module tb_instruction_fetch;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = '0;
    logic        out_ready = 1'b0;
    logic [31:0] imem_addr, imem_data, out_instr, out_pc;
    logic        out_valid, halted;

    logic [31:0] mem [DEPTH];

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[4:0]];

    instruction_fetch #(.DEPTH(DEPTH), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
    );

    typedef struct {
        int          pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    int          m_pc;
    bit          m_halt;
    int          m_last_pc;
    logic [31:0] m_last_instr;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit pop, fetch;
        if (!rst) begin
            mq.delete();
            m_pc = 0; m_halt = 0; m_last_pc = 0; m_last_instr = '0;
        end else if (branch_valid) begin
            mq.delete();
            m_pc = int'(branch_target % 32'd32);
            m_halt = 0;
        end else begin
            pop   = (mq.size() > 0) && out_ready;
            fetch = !m_halt && ((mq.size() < 2) || pop);
            if (pop) void'(mq.pop_front());
            if (fetch) begin
                mq.push_back('{m_pc, mem[m_pc]});
                if (m_pc == DEPTH - 1) begin
`ifdef IF_WRAP_EN
                    m_pc = 0;
`else
                    m_halt = 1;
`endif
                end else begin
                    m_pc++;
                end
            end
        end
        if (mq.size() > 0) begin
            m_last_pc    = mq[0].pc;
            m_last_instr = mq[0].instr;
        end
    endtask

    task automatic compare();
        check_eq("out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
        check_eq("out_pc",    out_pc,    m_last_pc);
        check_eq("out_instr", out_instr, m_last_instr);
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("halted",    {31'b0, halted}, {31'b0, m_halt});
    endtask

    task automatic cycle(input logic r, input logic bv, input logic [31:0] bt, input logic rdy);
        rst = r; branch_valid = bv; branch_target = bt; out_ready = rdy;
        @(posedge clk);
        model_edge();
        #1 compare();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

        // Reset, then free-running stream
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check_eq("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("reset_imem_addr", imem_addr, 32'd0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 1);

        // Backpressure saturates the queue at two entries
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
        check_eq("full_imem_addr", imem_addr, 32'd2);
        check_eq("full_out_pc", out_pc, 32'd0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1);

        // Branch while full
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        cycle(1, 1, 32'd13, 1);
        check_eq("branch_flush_valid", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1);

        // Only the low index bits of the target are used
        cycle(1, 1, 32'h25, 1);
        check_eq("branch_low_bits", imem_addr, 32'd5);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1);

        // End of memory, then leave via branch
        cycle(1, 1, 32'd20, 1);
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, 1);
`ifndef IF_WRAP_EN
        check_eq("end_halted", {31'b0, halted}, 32'd1);
        check_eq("end_imem_addr", imem_addr, 32'd31);
`endif
        cycle(1, 1, 32'd7, 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1);

        // Reset mid-stream with a full queue
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check_eq("midreset_valid", {31'b0, out_valid}, 32'd0);
        check_eq("midreset_out_pc", out_pc, 32'd0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 15) == 0),
                  $urandom,
                  ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
